// File: rtl/i2c_apb_pkg.sv
// rtl/i2c_apb_pkg.sv - shared types and constants for the i2c APB command master
package i2c_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

    // i2c core register map, byte offsets on the APB slave port
    localparam logic [31:0] I2C_REG_CTRL     = 32'h0000_0000;
    localparam logic [31:0] I2C_REG_STATUS   = 32'h0000_0004;
    localparam logic [31:0] I2C_REG_DATA     = 32'h0000_0008;
    localparam logic [31:0] I2C_REG_CMD      = 32'h0000_000C;
    localparam logic [31:0] I2C_REG_PRESCALE = 32'h0000_0010;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS wait-state counter with expire flag
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The master aborts on this cycle, so the counter never reaches its wrap point.
    assign expire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/i2c_apb_cmd_master.sv
// rtl/i2c_apb_cmd_master.sv - command/response front end driving one APB3 transfer at a time
module i2c_apb_cmd_master
    import i2c_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_mst_state_e    state, state_n;
    logic              pend, pend_n;
    logic              cmd_ready_n, rsp_valid_n, rsp_err_n, rsp_timeout_n;
    logic              psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n, rsp_rdata_n;
    logic              tmr_clear, tmr_enable, tmr_expire;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (PCLK),
        .rst    (PRESET),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expire (tmr_expire)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            pend        <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
        end else begin
            state       <= state_n;
            pend        <= pend_n;
            cmd_ready   <= cmd_ready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_err     <= rsp_err_n;
            rsp_timeout <= rsp_timeout_n;
            PSELx       <= psel_n;
            PENABLE     <= penable_n;
            PWRITE      <= pwrite_n;
            PADDR       <= paddr_n;
            PWDATA      <= pwdata_n;
        end
    end

    always_comb begin
        state_n       = state;
        pend_n        = pend;
        cmd_ready_n   = cmd_ready;
        rsp_valid_n   = rsp_valid;
        rsp_rdata_n   = rsp_rdata;
        rsp_err_n     = rsp_err;
        rsp_timeout_n = rsp_timeout;
        psel_n        = PSELx;
        penable_n     = PENABLE;
        pwrite_n      = PWRITE;
        paddr_n       = PADDR;
        pwdata_n      = PWDATA;
        tmr_clear     = 1'b0;
        tmr_enable    = 1'b0;

        case (state)
            IDLE: begin
                // pend marks the turnaround cycle between the handshake and SETUP
                if (pend) begin
                    pend_n  = 1'b0;
                    psel_n  = 1'b1;
                    state_n = SETUP;
                end else if (cmd_valid && cmd_ready) begin
                    pend_n      = 1'b1;
                    cmd_ready_n = 1'b0;
                    pwrite_n    = cmd_write;
                    paddr_n     = cmd_addr;
                    pwdata_n    = cmd_wdata;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                tmr_clear = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so a completion on the last allowed cycle is not a timeout
                if (PREADY) begin
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = PWRITE ? '0 : PRDATA;
                    rsp_err_n     = PSLVERR;
                    rsp_timeout_n = 1'b0;
                    state_n       = RESP;
                end else if (tmr_expire) begin
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = '0;
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                    state_n       = RESP;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_apb_cmd_master.sv
// tb/tb_i2c_apb_cmd_master.sv - directed self-checking bench for i2c_apb_cmd_master
module tb_i2c_apb_cmd_master;
    import i2c_apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    int vectors     = 0;
    int miscompares = 0;

    i2c_apb_cmd_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .PRDATA      (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Called at a negedge with cmd_ready high; returns at the negedge right after the handshake.
    task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        vectors++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, PWRITE} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want %b",
                     {cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, PWRITE}, 7'b1000000);
        end
        vectors++;
        if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {PADDR, PWDATA, rsp_rdata});
        end
        PRESET = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_read_fast();
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'hA5A5_0001;
        issue_cmd(1'b0, I2C_REG_STATUS, 32'hDEAD_BEEF);
        vectors++;
        if ({cmd_ready, PSELx, PENABLE, rsp_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rd_turnaround: got %b want 0000", {cmd_ready, PSELx, PENABLE, rsp_valid});
        end
        @(negedge PCLK);
        vectors++;
        if ({PSELx, PENABLE, PWRITE, PADDR} !== {3'b100, I2C_REG_STATUS}) begin
            miscompares++;
            $display("FAIL rd_setup: got %h want %h", {PSELx, PENABLE, PWRITE, PADDR}, {3'b100, I2C_REG_STATUS});
        end
        @(negedge PCLK);
        vectors++;
        if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL rd_access: got %b want 110", {PSELx, PENABLE, rsp_valid});
        end
        @(negedge PCLK);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE} !== 5'b10000) begin
            miscompares++;
            $display("FAIL rd_rsp_flags: got %b want 10000", {rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE});
        end
        vectors++;
        if (rsp_rdata !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL rd_rsp_data: got %h want a5a50001", rsp_rdata);
        end
        consume_rsp();
        vectors++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rd_consume: got %b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_write_wait();
        PREADY = 1'b0;
        PRDATA = 32'h1111_2222;
        issue_cmd(1'b1, I2C_REG_DATA, 32'h0000_00FF);
        for (int j = 1; j <= 6; j++) begin
            @(negedge PCLK);
            vectors++;
            if ({PSELx, PWRITE, PADDR, PWDATA} !== {2'b11, I2C_REG_DATA, 32'h0000_00FF}) begin
                miscompares++;
                $display("FAIL wr_stable_%0d: got %h want %h", j, {PSELx, PWRITE, PADDR, PWDATA},
                         {2'b11, I2C_REG_DATA, 32'h0000_00FF});
            end
            vectors++;
            if (PENABLE !== (j >= 2)) begin
                miscompares++;
                $display("FAIL wr_penable_%0d: got %b want %b", j, PENABLE, (j >= 2));
            end
            if (j == 6) PREADY = 1'b1;
        end
        @(negedge PCLK);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, rsp_rdata} !== {5'b10000, 32'h0}) begin
            miscompares++;
            $display("FAIL wr_rsp: got %h want %h", {rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, rsp_rdata},
                     {5'b10000, 32'h0});
        end
        PREADY = 1'b0;
        consume_rsp();
    endtask

    task automatic test_timeout();
        int access_cycles;
        access_cycles = 0;
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        issue_cmd(1'b0, I2C_REG_CTRL, 32'h0);
        for (int j = 1; j <= 17; j++) begin
            @(negedge PCLK);
            if (PENABLE === 1'b1) access_cycles++;
            vectors++;
            if ({PSELx, rsp_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL to_wait_%0d: got %b want 10", j, {PSELx, rsp_valid});
            end
        end
        vectors++;
        if (access_cycles != TO) begin
            miscompares++;
            $display("FAIL to_access_count: got %0d want %0d", access_cycles, TO);
        end
        @(negedge PCLK);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, rsp_rdata} !== {5'b11100, 32'h0}) begin
            miscompares++;
            $display("FAIL to_rsp: got %h want %h", {rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, rsp_rdata},
                     {5'b11100, 32'h0});
        end
        consume_rsp();
    endtask

    task automatic test_slverr();
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'hCAFE_0002;
        issue_cmd(1'b0, I2C_REG_CMD, 32'h0);
        repeat (3) @(negedge PCLK);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b110, 32'hCAFE_0002}) begin
            miscompares++;
            $display("FAIL slverr_rsp: got %h want %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {3'b110, 32'hCAFE_0002});
        end
        PSLVERR = 1'b0;
        PREADY  = 1'b0;
        consume_rsp();
    endtask

    task automatic test_late_ready();
        PREADY = 1'b0;
        PRDATA = 32'h5A5A_0016;
        issue_cmd(1'b0, I2C_REG_PRESCALE, 32'h0);
        repeat (17) @(negedge PCLK);
        vectors++;
        if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL late_last_access: got %b want 110", {PSELx, PENABLE, rsp_valid});
        end
        PREADY = 1'b1;
        @(negedge PCLK);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h5A5A_0016}) begin
            miscompares++;
            $display("FAIL late_rsp: got %h want %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {3'b100, 32'h5A5A_0016});
        end
        PREADY = 1'b0;
        consume_rsp();
    endtask

    task automatic test_back_to_back();
        PREADY = 1'b1;
        PRDATA = 32'h0000_0011;
        issue_cmd(1'b0, I2C_REG_DATA, 32'h0);
        repeat (3) @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = I2C_REG_CMD;
        cmd_wdata = 32'h0000_0042;
        for (int j = 0; j < 10; j++) begin
            @(negedge PCLK);
            vectors++;
            if ({rsp_valid, cmd_ready, PSELx, PENABLE, rsp_rdata} !== {4'b1000, 32'h0000_0011}) begin
                miscompares++;
                $display("FAIL b2b_hold_%0d: got %h want %h", j, {rsp_valid, cmd_ready, PSELx, PENABLE, rsp_rdata},
                         {4'b1000, 32'h0000_0011});
            end
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, cmd_ready, PSELx} !== 3'b010) begin
            miscompares++;
            $display("FAIL b2b_release: got %b want 010", {rsp_valid, cmd_ready, PSELx});
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        vectors++;
        if ({cmd_ready, PSELx} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_accept: got %b want 00", {cmd_ready, PSELx});
        end
        @(negedge PCLK);
        vectors++;
        if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, I2C_REG_CMD, 32'h0000_0042}) begin
            miscompares++;
            $display("FAIL b2b_setup2: got %h want %h", {PSELx, PENABLE, PWRITE, PADDR, PWDATA},
                     {3'b101, I2C_REG_CMD, 32'h0000_0042});
        end
        repeat (2) @(negedge PCLK);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0}) begin
            miscompares++;
            $display("FAIL b2b_rsp2: got %h want %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h0});
        end
        PREADY = 1'b0;
        consume_rsp();
    endtask

    task automatic test_reset_mid();
        PREADY = 1'b0;
        issue_cmd(1'b0, I2C_REG_STATUS, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        vectors++;
        if ({PSELx, PENABLE} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %b want 00", {PSELx, PENABLE});
        end
        @(negedge PCLK);
        vectors++;
        if ({PSELx, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
            miscompares++;
            $display("FAIL rst_mid_state: got %b want 0010", {PSELx, PENABLE, cmd_ready, rsp_valid});
        end
        PRESET = 1'b0;
        @(negedge PCLK);
        vectors++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_mid_no_rsp: got %b want 01", {rsp_valid, cmd_ready});
        end
        PREADY = 1'b1;
        PRDATA = 32'h0000_0077;
        issue_cmd(1'b0, I2C_REG_CTRL, 32'h0);
        repeat (3) @(negedge PCLK);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0000_0077}) begin
            miscompares++;
            $display("FAIL rst_mid_after: got %h want %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {3'b100, 32'h0000_0077});
        end
        consume_rsp();
    endtask

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        test_reset();
        test_read_fast();
        test_write_wait();
        test_timeout();
        test_slverr();
        test_late_ready();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
